gps_spi_frame_sched: RTL and testbench

Scheduler between the GPS front-end sign/magnitude outputs and the MCU SPI slave port. Captures one 4-bit I/Q sample per GPS_STROBE into a sample FIFO and sequences fixed-length SPI frames, SPI mode 0, to the MCU whenever a full frame is buffered. It replaces free-running DATAREADY pacing with FIFO-level-driven framing, a guaranteed SS-high gap between frames and overflow reporting.

---
 rtl/gps_spi_frame_sched_if.sv | 35 +++
 rtl/gps_spi_frame_sched.sv | 206 ++++++++++++++++++++
 tb/tb_gps_spi_frame_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gps_spi_frame_sched_if.sv
// gps_spi_frame_sched_if
//   Bundles the GPS front-end sample inputs, the MCU SPI outputs and the
//   scheduler status outputs into one interface.
//   slave  : used by gps_spi_frame_sched. It receives ENABLE and the GPS
//            signals, and drives the SPI and status signals.
//   master : used by whatever feeds the scheduler and watches it (a bench
//            or the parent block).
//   FIFO_DEPTH must match the scheduler's FIFO_DEPTH so that FIFO_LEVEL
//   has the same width on both sides.
interface gps_spi_frame_sched_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                        ENABLE;
  logic                        GPS_STROBE;
  logic                        GPS_I0;
  logic                        GPS_I1;
  logic                        GPS_Q0;
  logic                        GPS_Q1;
  logic                        MCU_SCK;
  logic                        MCU_SS;
  logic                        MCU_MOSI;
  logic                        FRAME_ACTIVE;
  logic                        OVERFLOW;
  logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL;

  modport slave (
    input  ENABLE, GPS_STROBE, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1,
    output MCU_SCK, MCU_SS, MCU_MOSI, FRAME_ACTIVE, OVERFLOW, FIFO_LEVEL
  );

  modport master (
    output ENABLE, GPS_STROBE, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1,
    input  MCU_SCK, MCU_SS, MCU_MOSI, FRAME_ACTIVE, OVERFLOW, FIFO_LEVEL
  );
endinterface

// File: rtl/gps_spi_frame_sched.sv
// gps_spi_frame_sched
//   Captures one 4-bit I/Q sample {I0,I1,Q0,Q1} per GPS_STROBE into a sample
//   FIFO. Whenever a whole frame of samples is buffered and ENABLE is high,
//   it sends a fixed-length SPI mode-0 frame to the MCU. The bits go MSB
//   first, and the older sample of each byte goes in the high nibble. After
//   each frame the scheduler keeps MCU_SS high for at least SS_GAP cycles.
//   If a sample arrives while the FIFO is full, the sample is dropped and
//   OVERFLOW is set; OVERFLOW stays set until RESET.
// Ports:
//   MCU_CLK_25_000 : system clock; all logic runs on its rising edge.
//   RESET          : synchronous reset, active-high. It aborts any frame in
//                    progress and discards all buffered samples.
//   bus (slave)    : ENABLE, GPS_STROBE, GPS_I0/I1/Q0/Q1 in;
//                    MCU_SCK, MCU_SS, MCU_MOSI, FRAME_ACTIVE, OVERFLOW and
//                    FIFO_LEVEL out. Every output is registered.
module gps_spi_frame_sched #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_BYTES = 4,
  parameter int SS_GAP      = 2
) (
  input  logic                  MCU_CLK_25_000,
  input  logic                  RESET,
  gps_spi_frame_sched_if.slave  bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int N_BITS = 8 * FRAME_BYTES;
  localparam int BIT_W  = $clog2(N_BITS);
  localparam int GAP_W  = $clog2(SS_GAP + 1);

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_FRAME = LVL_W'(2 * FRAME_BYTES);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(N_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(SS_GAP);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t           state;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             overflow;

  // shreg holds the bits of the current sample that are not yet on MOSI.
  logic [2:0]       shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             sck;
  logic             ss_n;
  logic             mosi;
  logic             frame_active;

  logic [3:0]       in_sample;
  logic [3:0]       pop_data;
  logic             gap_done;
  logic             start_frame;
  logic             nibble_pop;
  logic             pop;
  logic             push;

  // The SS gap counts from the SS rising edge. The cycle in which the gap
  // completes also serves as IDLE's first cycle, so a frame can start on
  // exactly that edge.
  // A frame pops one sample when it starts. It pops another each time a
  // nibble boundary passes, except after the final bit, so each frame pops
  // exactly 2*FRAME_BYTES samples.
  // A pop in the same cycle frees a slot, so a push into a full FIFO can
  // still be accepted.
  assign in_sample   = {bus.GPS_I0, bus.GPS_I1, bus.GPS_Q0, bus.GPS_Q1};
  assign pop_data    = mem[rd_ptr];
  assign gap_done    = (state == GAP) && (gap_cnt == GAP_END);
  assign start_frame = bus.ENABLE && (level >= LVL_FRAME) &&
                       ((state == IDLE) || gap_done);
  assign nibble_pop  = (state == SHIFT_HI) && (bit_cnt != BIT_LAST) &&
                       (bit_cnt[1:0] == 2'b11);
  assign pop         = start_frame || nibble_pop;
  assign push        = bus.GPS_STROBE && ((level != LVL_FULL) || pop);

  // Sample storage. This block has no reset, so it can map onto a small
  // RAM. After a reset the pointers and the level are cleared, so any old
  // contents are unreachable.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (push) begin
      mem[wr_ptr] <= in_sample;
    end
  end

  // FIFO bookkeeping. Both pointers wrap naturally because FIFO_DEPTH is a
  // power of two. The level changes only when exactly one of push and pop
  // happens. A strobe that finds no slot sets the sticky overflow flag.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
      if (bus.GPS_STROBE && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Frame sequencer. Each bit takes two cycles. In SHIFT_LO the sequencer
  // raises SCK while MOSI stays unchanged, and the MCU samples MOSI on that
  // edge. In SHIFT_HI it lowers SCK and presents the next bit, reloading
  // from the FIFO at nibble boundaries. HOLD keeps SS low for one more
  // cycle after the last falling SCK edge. The frame-start check comes
  // before the case statement because a frame can start from IDLE or from
  // the final GAP cycle.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      state        <= IDLE;
      sck          <= 1'b0;
      ss_n         <= 1'b1;
      mosi         <= 1'b0;
      frame_active <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
    end else if (start_frame) begin
      state        <= SHIFT_LO;
      ss_n         <= 1'b0;
      frame_active <= 1'b1;
      sck          <= 1'b0;
      mosi         <= pop_data[3];
      shreg        <= pop_data[2:0];
      bit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          sck <= 1'b0;
        end
        SHIFT_LO: begin
          sck   <= 1'b1;
          state <= SHIFT_HI;
        end
        SHIFT_HI: begin
          sck <= 1'b0;
          if (bit_cnt == BIT_LAST) begin
            mosi  <= 1'b0;
            state <= HOLD;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            state   <= SHIFT_LO;
            if (nibble_pop) begin
              mosi  <= pop_data[3];
              shreg <= pop_data[2:0];
            end else begin
              mosi  <= shreg[2];
              shreg <= {shreg[1:0], 1'b0};
            end
          end
        end
        HOLD: begin
          ss_n         <= 1'b1;
          frame_active <= 1'b0;
          gap_cnt      <= GAP_W'(1);
          state        <= GAP;
        end
        GAP: begin
          if (gap_done) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          ss_n         <= 1'b1;
          sck          <= 1'b0;
          mosi         <= 1'b0;
          frame_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MCU_SCK      = sck;
  assign bus.MCU_SS       = ss_n;
  assign bus.MCU_MOSI     = mosi;
  assign bus.FRAME_ACTIVE = frame_active;
  assign bus.OVERFLOW     = overflow;
  assign bus.FIFO_LEVEL   = level;

endmodule

// File: tb/tb_gps_spi_frame_sched.sv
// tb_gps_spi_frame_sched
//   Directed bench for gps_spi_frame_sched with its default parameters. It
//   drives samples through the master modport and decodes the SPI frames.
//   It compares frame length, SCK rise count, data order, the inter-frame
//   gap, FIFO_LEVEL and OVERFLOW against values worked out by hand.
module tb_gps_spi_frame_sched;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  bit          gotA, gotB;
  int          waitA, waitB, lowA, lowB, riseA, riseB, faA, faB;
  logic [31:0] dataA, dataB;

  gps_spi_frame_sched_if #(.FIFO_DEPTH(16)) bus ();

  gps_spi_frame_sched #(
    .FIFO_DEPTH (16),
    .FRAME_BYTES(4),
    .SS_GAP     (2)
  ) dut (
    .MCU_CLK_25_000(clk),
    .RESET         (rst),
    .bus           (bus.slave)
  );

  // 25 MHz clock
  always #20 clk = ~clk;

  // Each comparison counts one test. A failing comparison also counts one
  // failure and reports the tag with the observed and expected values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one strobed sample, {I0,I1,Q0,Q1} = s, for one clock edge.
  task automatic applyStimulus(input logic [3:0] s);
    bus.GPS_I0     = s[3];
    bus.GPS_I1     = s[2];
    bus.GPS_Q0     = s[1];
    bus.GPS_Q1     = s[0];
    bus.GPS_STROBE = 1'b1;
    @(negedge clk);
    bus.GPS_STROBE = 1'b0;
  endtask

  // Pushes eight samples, taking the most significant nibble first.
  task automatic pushWord(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(w[i*4 +: 4]);
    end
  endtask

  // Waits at most budget cycles for SS to go low, then follows the frame
  // at each falling edge. It shifts in MOSI on every rise of SCK and
  // counts the SS-low cycles.
  task automatic captureFrame(input int budget, output bit got, output int waited,
                              output int ssLow, output int rises,
                              output logic [31:0] data, output int faBad);
    logic prevSck;
    got = 1'b0; waited = 0; ssLow = 0; rises = 0; data = '0; faBad = 0;
    prevSck = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.MCU_SS === 1'b0) begin
        got = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (got) begin
      while (bus.MCU_SS === 1'b0 && ssLow < 200) begin
        ssLow++;
        if (bus.FRAME_ACTIVE !== 1'b1) faBad++;
        if (bus.MCU_SCK === 1'b1 && prevSck === 1'b0) begin
          rises++;
          data = {data[30:0], bus.MCU_MOSI};
        end
        prevSck = bus.MCU_SCK;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.ENABLE     = 1'b0;
    bus.GPS_STROBE = 1'b0;
    bus.GPS_I0     = 1'b0;
    bus.GPS_I1     = 1'b0;
    bus.GPS_Q0     = 1'b0;
    bus.GPS_Q1     = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_sck", bus.MCU_SCK, 0);
    checkOutput("rst_ss", bus.MCU_SS, 1);
    checkOutput("rst_mosi", bus.MCU_MOSI, 0);
    checkOutput("rst_active", bus.FRAME_ACTIVE, 0);
    checkOutput("rst_ovf", bus.OVERFLOW, 0);
    checkOutput("rst_level", bus.FIFO_LEVEL, 0);
    rst = 1'b0;
    @(negedge clk);

    pushWord(32'h12345678);
    checkOutput("t1_level_pre", bus.FIFO_LEVEL, 8);
    bus.ENABLE = 1'b1;
    captureFrame(20, gotA, waitA, lowA, riseA, dataA, faA);
    checkOutput("t1_got", gotA, 1);
    checkOutput("t1_ss_low", lowA, 65);
    checkOutput("t1_rises", riseA, 32);
    checkOutput("t1_data", dataA, 32'h12345678);
    checkOutput("t1_active", faA, 0);
    checkOutput("t1_active_off", bus.FRAME_ACTIVE, 0);
    checkOutput("t1_level_post", bus.FIFO_LEVEL, 0);
    checkOutput("t1_ovf", bus.OVERFLOW, 0);

    fork
      begin
        pushWord(32'h9ABCDEF0);
        pushWord(32'h12345678);
      end
      begin
        captureFrame(40, gotA, waitA, lowA, riseA, dataA, faA);
        captureFrame(40, gotB, waitB, lowB, riseB, dataB, faB);
      end
    join
    checkOutput("t2_gotA", gotA, 1);
    checkOutput("t2_lowA", lowA, 65);
    checkOutput("t2_dataA", dataA, 32'h9ABCDEF0);
    checkOutput("t2_gotB", gotB, 1);
    checkOutput("t2_gap", waitB, 2);
    checkOutput("t2_lowB", lowB, 65);
    checkOutput("t2_dataB", dataB, 32'h12345678);
    checkOutput("t2_level", bus.FIFO_LEVEL, 0);

    bus.ENABLE = 1'b0;
    pushWord(32'h13579BDF);
    pushWord(32'h02468ACE);
    applyStimulus(4'h5);
    checkOutput("t3_level_full", bus.FIFO_LEVEL, 16);
    checkOutput("t3_ovf", bus.OVERFLOW, 1);
    bus.ENABLE = 1'b1;
    captureFrame(20, gotA, waitA, lowA, riseA, dataA, faA);
    captureFrame(20, gotB, waitB, lowB, riseB, dataB, faB);
    checkOutput("t3_dataA", dataA, 32'h13579BDF);
    checkOutput("t3_dataB", dataB, 32'h02468ACE);
    captureFrame(30, gotA, waitA, lowA, riseA, dataA, faA);
    checkOutput("t3_no_third", gotA, 0);
    checkOutput("t3_level_post", bus.FIFO_LEVEL, 0);

    rst = 1'b1;
    bus.ENABLE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t4_ovf_clr", bus.OVERFLOW, 0);
    pushWord(32'h01234567);
    pushWord(32'h89ABCDEF);
    checkOutput("t4_level_full", bus.FIFO_LEVEL, 16);
    bus.ENABLE = 1'b1;
    applyStimulus(4'hA);
    checkOutput("t4_level_startpop", bus.FIFO_LEVEL, 16);
    repeat (7) @(negedge clk);
    applyStimulus(4'h5);
    checkOutput("t4_ss_low", bus.MCU_SS, 0);
    checkOutput("t4_level_nibpop", bus.FIFO_LEVEL, 16);
    checkOutput("t4_ovf_nibpop", bus.OVERFLOW, 0);
    captureFrame(5, gotA, waitA, lowA, riseA, dataA, faA);
    checkOutput("t4_partial_rises", riseA, 28);
    checkOutput("t4_partial_data", dataA, 32'h01234567);
    fork
      begin
        applyStimulus(4'h3);
        applyStimulus(4'hC);
        applyStimulus(4'h7);
        applyStimulus(4'hE);
        applyStimulus(4'h1);
        applyStimulus(4'h9);
      end
      begin
        captureFrame(20, gotA, waitA, lowA, riseA, dataA, faA);
        captureFrame(20, gotB, waitB, lowB, riseB, dataB, faB);
      end
    join
    checkOutput("t4_dataA", dataA, 32'h89ABCDEF);
    checkOutput("t4_dataB", dataB, 32'hA53C7E19);
    checkOutput("t4_ovf_end", bus.OVERFLOW, 0);

    bus.ENABLE = 1'b0;
    pushWord(32'hFEDCBA98);
    pushWord(32'h76543210);
    checkOutput("t5_level_pre", bus.FIFO_LEVEL, 16);
    bus.ENABLE = 1'b1;
    fork
      captureFrame(20, gotA, waitA, lowA, riseA, dataA, faA);
      begin
        repeat (21) @(negedge clk);
        bus.ENABLE = 1'b0;
      end
    join
    checkOutput("t5_ss_low", lowA, 65);
    checkOutput("t5_rises", riseA, 32);
    checkOutput("t5_data", dataA, 32'hFEDCBA98);
    captureFrame(100, gotB, waitB, lowB, riseB, dataB, faB);
    checkOutput("t5_no_second", gotB, 0);
    checkOutput("t5_level_held", bus.FIFO_LEVEL, 8);

    bus.ENABLE = 1'b1;
    repeat (41) @(negedge clk);
    checkOutput("t6_midframe", bus.MCU_SS, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_ss", bus.MCU_SS, 1);
    checkOutput("t6_sck", bus.MCU_SCK, 0);
    checkOutput("t6_mosi", bus.MCU_MOSI, 0);
    checkOutput("t6_active", bus.FRAME_ACTIVE, 0);
    checkOutput("t6_level", bus.FIFO_LEVEL, 0);
    rst = 1'b0;
    fork
      pushWord(32'h2468ACE1);
      captureFrame(40, gotA, waitA, lowA, riseA, dataA, faA);
    join
    checkOutput("t6_got", gotA, 1);
    checkOutput("t6_ss_low", lowA, 65);
    checkOutput("t6_rises", riseA, 32);
    checkOutput("t6_data", dataA, 32'h2468ACE1);
    checkOutput("t6_level_post", bus.FIFO_LEVEL, 0);
    checkOutput("t6_ovf", bus.OVERFLOW, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
